dbus_master_bridge: RTL and testbench
=====================================

Name: dbus_master_bridge

Overview:
- Master-side bridge between the darkriscv core data port and the shared device bus (EN/RE/RACK/WE/WACK/ADDR/DATA).
- Converts single-cycle core load/store strobes into held, acknowledged device-bus transactions and stalls the core via HLT until the transaction completes.
- The device bus has no byte enables, so partial-word stores are executed as read-modify-write.
- One instance sits between the core and all device-bus providers.

Parameters:
- BASE, 32'h8000_0000, address window base.
- MASK, 32'hF000_0000, window mask; hit = (DADDR & MASK) == BASE.
- TIMEOUT, 255, max cycles waiting for RACK/WACK (8-bit counter; only with DBUS_TIMEOUT_EN).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RES_N  in  1  asynchronous active-low reset.
- DADDR  in  32  core byte address.
- DATAO  in  32  core store data.
- BE  in  4  core byte enables.
- RD  in  1  core load strobe.
- WR  in  1  core store strobe.
- DATAI  out  32  load data to core.
- HLT  out  1  core stall.
- ERR  out  1  sticky timeout flag.
- ERR_CLR  in  1  clears ERR.
- EN  out  1  bus transaction enable.
- RE  out  1  read request.
- WE  out  1  write request.
- RACK  in  1  read acknowledge.
- WACK  in  1  write acknowledge.
- ADDR  out  32  word address (DADDR with [1:0] forced to 0).
- DATA_O  out  32  write data.
- DATA_OE  out  1  DATA tristate enable; DATA = DATA_OE ? DATA_O : 'z at the top level.
- DATA_I  in  32  sampled DATA.

Behaviour:
- Reset (async, RES_N=0): state IDLE; EN=RE=WE=DATA_OE=0, ADDR=0, DATA_O=0, DATAI=0, ERR=0, counter=0. HLT=0 while RES_N=0.
- Reset mid-transaction aborts immediately. No ack is awaited, and acks arriving after reset are ignored in IDLE.
- States: IDLE, RD_REQ, WR_REQ, RMW_RD, RMW_WR, DONE.
- IDLE:
  - Request = (RD|WR) & hit. Miss requests are ignored and HLT stays 0.
  - HLT is combinational: (IDLE & request) | (state not in {IDLE, DONE}), so the core stalls in the request cycle.
  - On request, latch ADDR, DATAO, BE and RD/WR into holding registers.
  - WR & BE==4'hF -> WR_REQ. WR & BE!=4'hF -> RMW_RD. RD -> RD_REQ.
  - RD&WR together is treated as a write. WR with BE==0 -> DONE directly, no bus cycle.
- RD_REQ:
  - EN=RE=1 from the first cycle in state, held until RACK is sampled 1.
  - On that edge, DATAI<=DATA_I, then go to DONE.
- WR_REQ:
  - EN=WE=DATA_OE=1 and DATA_O=latched data, held until WACK is sampled 1, then go to DONE.
- RMW_RD:
  - Same as RD_REQ, but on RACK capture the merge word: byte i = BE[i] ? DATAO byte i : DATA_I byte i.
  - Then go to RMW_WR. EN stays 1, RE drops and WE rises on the next cycle; RE and WE are never both 1.
- RMW_WR: same as WR_REQ using the merged word, then go to DONE.
- DONE:
  - EN=RE=WE=DATA_OE=0 and HLT=0 for exactly one cycle (mandatory bus idle gap).
  - The core consumes DATAI in this cycle. DATAI holds its value until the next read completes.
  - Next state is IDLE. Requests are only accepted in IDLE, so back-to-back accesses are separated by at least 1 idle bus cycle.
- Latency (zero-wait provider that acks in the first request cycle):
  - read: HLT high 2 cycles;
  - full write: 2 cycles;
  - RMW: 3 cycles.
- ACK sampled outside the matching request state is ignored.
- ERR_CLR and a timeout in the same cycle: set wins.

Optional Feature:
- Macro: DBUS_TIMEOUT_EN.
- Defined: an 8-bit counter resets on entry to each *_REQ/RMW_* state and increments each waiting cycle. When it reaches TIMEOUT with no ack:
  - abort to DONE and set ERR;
  - reads return DATAI=32'hFFFF_FFFF;
  - RMW timing out in RMW_RD skips its write.
- Not defined: no counter; the bridge waits indefinitely. ERR is tied to 0 and ERR_CLR is unused.

Test Plan:
- RD, DADDR=32'h8000_0104, provider acks 2 cycles later with 32'hDEADBEEF -> ADDR=32'h8000_0104; RE held 3 cycles; DATAI=32'hDEADBEEF in DONE; HLT high 4 cycles.
- WR, BE=4'hF, DATAO=32'h1234_5678, zero-wait ack -> single WE pulse, DATA_OE=1 with DATA_O=32'h1234_5678, HLT high 2 cycles, RE never asserted.
- WR, BE=4'b0010, DATAO=32'h0000_AB00, bus read returns 32'h1122_3344 -> a read followed by a write of 32'h1122_AB44; RE and WE never overlap.
- RD to 32'h0000_0010 (miss) -> EN stays 0, HLT stays 0.
- With DBUS_TIMEOUT_EN and TIMEOUT=8, provider never acks a read -> abort after 8 wait cycles, DATAI=32'hFFFF_FFFF, ERR=1; ERR_CLR clears it.
- RES_N pulled low while in WR_REQ -> all outputs 0 asynchronously; after release, a new read completes normally.

Source files
------------

// File: rtl/dbus_master_bridge.sv
// dbus_master_bridge: turns single-cycle darkriscv load/store strobes into
// held, acknowledged device-bus transactions and stalls the core through HLT
// until the access completes. The device bus has no byte enables, so partial
// stores are executed as read-modify-write.
// Optional build macro DBUS_TIMEOUT_EN adds an ack timeout with a sticky ERR.
module dbus_master_bridge #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter logic [31:0] MASK    = 32'hF000_0000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RES_N,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  input  logic [3:0]  BE,
  input  logic        RD,
  input  logic        WR,
  output logic [31:0] DATAI,
  output logic        HLT,
  output logic        ERR,
  input  logic        ERR_CLR,
  output logic        EN,
  output logic        RE,
  output logic        WE,
  input  logic        RACK,
  input  logic        WACK,
  output logic [31:0] ADDR,
  output logic [31:0] DATA_O,
  output logic        DATA_OE,
  input  logic [31:0] DATA_I
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    WR_REQ = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Last wait cycle before an unacknowledged access is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] hold_data;
  logic [3:0]  hold_be;
  logic        hit;
  logic        req;

  // Byte-wise merge of store data over the word read back from the bus.
  function automatic logic [31:0] merge_bytes(input logic [31:0] wdata,
                                              input logic [31:0] rdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = rdata;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  assign hit = (DADDR & MASK) == BASE;
  assign req = (RD | WR) & hit;

  // Stall in the request cycle itself and in every bus-active state.
  assign HLT = RES_N & (((state == IDLE) & req) |
                        ((state != IDLE) & (state != DONE)));

  // Store operands captured at request time for the read-modify-write merge.
  always_ff @(posedge CLK) begin
    if ((state == IDLE) && req) begin
      hold_data <= DATAO;
      hold_be   <= BE;
    end
  end

`ifdef DBUS_TIMEOUT_EN
  logic [7:0] wait_cnt;
`else
  logic [8:0] unused_cfg;
  assign unused_cfg = {ERR_CLR, TO_LAST};
  assign ERR = 1'b0;
`endif

  // Transaction FSM with registered bus outputs and load data.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state   <= IDLE;
      EN      <= 1'b0;
      RE      <= 1'b0;
      WE      <= 1'b0;
      DATA_OE <= 1'b0;
      ADDR    <= 32'h0;
      DATA_O  <= 32'h0;
      DATAI   <= 32'h0;
`ifdef DBUS_TIMEOUT_EN
      ERR      <= 1'b0;
      wait_cnt <= 8'h0;
`endif
    end else begin
`ifdef DBUS_TIMEOUT_EN
      // A timeout later in this block overrides the clear.
      if (ERR_CLR) ERR <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            ADDR <= {DADDR[31:2], 2'b00};
`ifdef DBUS_TIMEOUT_EN
            wait_cnt <= 8'h0;
`endif
            // RD and WR together is handled as a store.
            if (WR) begin
              if (BE == 4'hF) begin
                state   <= WR_REQ;
                EN      <= 1'b1;
                WE      <= 1'b1;
                DATA_OE <= 1'b1;
                DATA_O  <= DATAO;
              end else if (BE == 4'h0) begin
                state <= DONE;
              end else begin
                state <= RMW_RD;
                EN    <= 1'b1;
                RE    <= 1'b1;
              end
            end else begin
              state <= RD_REQ;
              EN    <= 1'b1;
              RE    <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (RACK) begin
            DATAI <= DATA_I;
            EN    <= 1'b0;
            RE    <= 1'b0;
            state <= DONE;
          end
`ifdef DBUS_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            DATAI <= 32'hFFFF_FFFF;
            EN    <= 1'b0;
            RE    <= 1'b0;
            ERR   <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        WR_REQ, RMW_WR: begin
          if (WACK) begin
            EN      <= 1'b0;
            WE      <= 1'b0;
            DATA_OE <= 1'b0;
            state   <= DONE;
          end
`ifdef DBUS_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            EN      <= 1'b0;
            WE      <= 1'b0;
            DATA_OE <= 1'b0;
            ERR     <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        RMW_RD: begin
          // EN stays high; RE hands over to WE so they never overlap.
          if (RACK) begin
            DATA_O  <= merge_bytes(hold_data, DATA_I, hold_be);
            RE      <= 1'b0;
            WE      <= 1'b1;
            DATA_OE <= 1'b1;
            state   <= RMW_WR;
`ifdef DBUS_TIMEOUT_EN
            wait_cnt <= 8'h0;
`endif
          end
`ifdef DBUS_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            EN    <= 1'b0;
            RE    <= 1'b0;
            ERR   <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_master_bridge.sv
// Testbench for dbus_master_bridge: a bus provider with programmable ack
// delay plus a scoreboard of expected bus transactions.
module tb_dbus_master_bridge;

  logic        CLK = 1'b0;
  logic        RES_N = 1'b0;
  logic [31:0] DADDR = 32'h0;
  logic [31:0] DATAO = 32'h0;
  logic [3:0]  BE = 4'h0;
  logic        RD = 1'b0;
  logic        WR = 1'b0;
  logic [31:0] DATAI;
  logic        HLT;
  logic        ERR;
  logic        ERR_CLR = 1'b0;
  logic        EN;
  logic        RE;
  logic        WE;
  logic        RACK = 1'b0;
  logic        WACK = 1'b0;
  logic [31:0] ADDR;
  logic [31:0] DATA_O;
  logic        DATA_OE;
  logic [31:0] DATA_I = 32'h0;

  dbus_master_bridge #(
    .BASE    (32'h8000_0000),
    .MASK    (32'hF000_0000),
    .TIMEOUT (8)
  ) dut (
    .CLK     (CLK),
    .RES_N   (RES_N),
    .DADDR   (DADDR),
    .DATAO   (DATAO),
    .BE      (BE),
    .RD      (RD),
    .WR      (WR),
    .DATAI   (DATAI),
    .HLT     (HLT),
    .ERR     (ERR),
    .ERR_CLR (ERR_CLR),
    .EN      (EN),
    .RE      (RE),
    .WE      (WE),
    .RACK    (RACK),
    .WACK    (WACK),
    .ADDR    (ADDR),
    .DATA_O  (DATA_O),
    .DATA_OE (DATA_OE),
    .DATA_I  (DATA_I)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int rd_delay = 0;
  int wr_delay = 0;
  logic [31:0] rd_word = 32'h0;
  int rcnt = 0;
  int wcnt = 0;
  int overlap_cnt = 0;

  int hlt_cyc, re_cyc, we_cyc, en_cyc;
  logic [31:0] done_datai;
  logic done_bus;
  bit run_to;

  // Bus provider: acks after rd_delay/wr_delay request cycles; each ack is
  // matched against the oldest expected transaction.
  always @(negedge CLK) begin
    txn_t t;
    if (RE && WE) overlap_cnt++;
    if (EN && RE) begin
      if (rcnt == rd_delay) begin
        RACK = 1'b1;
        DATA_I = rd_word;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_read unexpected read ADDR=%h", ADDR);
        end else begin
          t = exp_q.pop_front();
          if (t.is_wr || ADDR !== t.addr) begin
            failures++;
            $display("FAIL sb_read got read ADDR=%h expected wr=%0d ADDR=%h", ADDR, t.is_wr, t.addr);
          end
        end
      end else begin
        RACK = 1'b0;
      end
      rcnt++;
    end else begin
      RACK = 1'b0;
      rcnt = 0;
    end
    if (EN && WE) begin
      if (wcnt == wr_delay) begin
        WACK = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_write unexpected write ADDR=%h DATA_O=%h", ADDR, DATA_O);
        end else begin
          t = exp_q.pop_front();
          if (!t.is_wr || ADDR !== t.addr || DATA_O !== t.data || DATA_OE !== 1'b1) begin
            failures++;
            $display("FAIL sb_write got ADDR=%h DATA_O=%h OE=%b expected wr=%0d ADDR=%h DATA_O=%h OE=1",
                     ADDR, DATA_O, DATA_OE, t.is_wr, t.addr, t.data);
          end
        end
      end else begin
        WACK = 1'b0;
      end
      wcnt++;
    end else begin
      WACK = 1'b0;
      wcnt = 0;
    end
  end

  // Issue one core strobe and follow it until HLT drops (or a cycle budget).
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
    hlt_cyc = 0; re_cyc = 0; we_cyc = 0; en_cyc = 0; run_to = 0;
    @(negedge CLK);
    RD = rd; WR = wr; DADDR = addr; DATAO = data; BE = be;
    #1;
    if (HLT) hlt_cyc++;
    if (EN) en_cyc++;
    @(negedge CLK);
    RD = 1'b0; WR = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (RE) re_cyc++;
      if (WE) we_cyc++;
      if (EN) en_cyc++;
      if (!HLT) begin
        done_datai = DATAI;
        done_bus = EN | RE | WE | DATA_OE;
        return;
      end
      hlt_cyc++;
      @(negedge CLK);
    end
    run_to = 1;
  endtask

  task automatic test_reset();
    RD = 1'b1; DADDR = 32'h8000_0000;
    #12;
    checks++;
    if ({EN, RE, WE, DATA_OE, HLT, ERR} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got EN/RE/WE/OE/HLT/ERR=%b expected 000000", {EN, RE, WE, DATA_OE, HLT, ERR});
    end
    checks++;
    if (ADDR !== 32'h0 || DATA_O !== 32'h0 || DATAI !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got ADDR=%h DATA_O=%h DATAI=%h expected all 0", ADDR, DATA_O, DATAI);
    end
    RD = 1'b0;
    @(negedge CLK);
    RES_N = 1'b1;
  endtask

  task automatic test_read_wait();
    rd_delay = 2; rd_word = 32'hDEAD_BEEF;
    exp_q.push_back('{1'b0, 32'h8000_0104, 32'h0});
    run_access(1'b1, 1'b0, 32'h8000_0104, 32'h0, 4'hF);
    checks++;
    if (run_to || hlt_cyc != 4 || re_cyc != 3) begin
      failures++;
      $display("FAIL read_wait got to=%0d hlt=%0d re=%0d expected to=0 hlt=4 re=3", run_to, hlt_cyc, re_cyc);
    end
    checks++;
    if (done_datai !== 32'hDEAD_BEEF || done_bus !== 1'b0) begin
      failures++;
      $display("FAIL read_data got DATAI=%h bus=%b expected DATAI=deadbeef bus=0", done_datai, done_bus);
    end
  endtask

  task automatic test_full_write();
    wr_delay = 0;
    exp_q.push_back('{1'b1, 32'h8000_0200, 32'h1234_5678});
    run_access(1'b0, 1'b1, 32'h8000_0200, 32'h1234_5678, 4'hF);
    checks++;
    if (run_to || hlt_cyc != 2 || we_cyc != 1 || re_cyc != 0) begin
      failures++;
      $display("FAIL full_write got to=%0d hlt=%0d we=%0d re=%0d expected 0/2/1/0", run_to, hlt_cyc, we_cyc, re_cyc);
    end
    checks++;
    if (done_datai !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL datai_hold got DATAI=%h expected deadbeef", done_datai);
    end
  endtask

  task automatic test_rmw();
    rd_delay = 0; wr_delay = 0; rd_word = 32'h1122_3344; overlap_cnt = 0;
    exp_q.push_back('{1'b0, 32'h8000_0300, 32'h0});
    exp_q.push_back('{1'b1, 32'h8000_0300, 32'h1122_AB44});
    run_access(1'b0, 1'b1, 32'h8000_0300, 32'h0000_AB00, 4'b0010);
    checks++;
    if (run_to || hlt_cyc != 3 || re_cyc != 1 || we_cyc != 1 || en_cyc != 2 || overlap_cnt != 0) begin
      failures++;
      $display("FAIL rmw_zero got to=%0d hlt=%0d re=%0d we=%0d en=%0d ovl=%0d expected 0/3/1/1/2/0",
               run_to, hlt_cyc, re_cyc, we_cyc, en_cyc, overlap_cnt);
    end
    checks++;
    if (done_datai !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rmw_datai got DATAI=%h expected deadbeef", done_datai);
    end
    rd_delay = 1; wr_delay = 1; rd_word = 32'h1122_3344;
    exp_q.push_back('{1'b0, 32'h8000_0304, 32'h0});
    exp_q.push_back('{1'b1, 32'h8000_0304, 32'hAA22_33DD});
    run_access(1'b0, 1'b1, 32'h8000_0305, 32'hAABB_CCDD, 4'b1001);
    checks++;
    if (run_to || hlt_cyc != 5 || overlap_cnt != 0) begin
      failures++;
      $display("FAIL rmw_wait got to=%0d hlt=%0d ovl=%0d expected 0/5/0", run_to, hlt_cyc, overlap_cnt);
    end
  endtask

  task automatic test_miss_and_empty();
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    checks++;
    if (run_to || hlt_cyc != 0 || en_cyc != 0 || done_bus !== 1'b0) begin
      failures++;
      $display("FAIL miss got to=%0d hlt=%0d en=%0d expected 0/0/0", run_to, hlt_cyc, en_cyc);
    end
    run_access(1'b0, 1'b1, 32'h8000_0400, 32'hFFFF_FFFF, 4'h0);
    checks++;
    if (run_to || hlt_cyc != 1 || en_cyc != 0) begin
      failures++;
      $display("FAIL be_zero got to=%0d hlt=%0d en=%0d expected 0/1/0", run_to, hlt_cyc, en_cyc);
    end
    wr_delay = 0;
    exp_q.push_back('{1'b1, 32'h8000_0500, 32'hCAFE_F00D});
    run_access(1'b1, 1'b1, 32'h8000_0500, 32'hCAFE_F00D, 4'hF);
    checks++;
    if (run_to || hlt_cyc != 2 || we_cyc != 1 || re_cyc != 0) begin
      failures++;
      $display("FAIL rd_wr_both got to=%0d hlt=%0d we=%0d re=%0d expected 0/2/1/0", run_to, hlt_cyc, we_cyc, re_cyc);
    end
  endtask

  task automatic test_back_to_back();
    rd_delay = 0; rd_word = 32'hA5A5_0001;
    exp_q.push_back('{1'b0, 32'h8000_0104, 32'h0});
    run_access(1'b1, 1'b0, 32'h8000_0106, 32'h0, 4'hF);
    checks++;
    if (run_to || hlt_cyc != 2 || done_datai !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL b2b_first got to=%0d hlt=%0d DATAI=%h expected 0/2/a5a50001", run_to, hlt_cyc, done_datai);
    end
    rd_word = 32'h5A5A_0002;
    exp_q.push_back('{1'b0, 32'h8FFF_FFFC, 32'h0});
    run_access(1'b1, 1'b0, 32'h8FFF_FFFF, 32'h0, 4'hF);
    checks++;
    if (run_to || hlt_cyc != 2 || done_datai !== 32'h5A5A_0002) begin
      failures++;
      $display("FAIL b2b_second got to=%0d hlt=%0d DATAI=%h expected 0/2/5a5a0002", run_to, hlt_cyc, done_datai);
    end
  endtask

  task automatic test_reset_mid_write();
    wr_delay = 1000;
    @(negedge CLK);
    WR = 1'b1; DADDR = 32'h8000_0600; DATAO = 32'h55AA_55AA; BE = 4'hF;
    @(negedge CLK);
    WR = 1'b0;
    #1;
    checks++;
    if (WE !== 1'b1 || DATA_OE !== 1'b1) begin
      failures++;
      $display("FAIL mid_write_active got WE=%b OE=%b expected 1/1", WE, DATA_OE);
    end
    RD = 1'b1; DADDR = 32'h8000_0000;
    #1;
    RES_N = 1'b0;
    #1;
    checks++;
    if ({EN, RE, WE, DATA_OE, HLT} !== 5'b0 || ADDR !== 32'h0 || DATA_O !== 32'h0 || DATAI !== 32'h0) begin
      failures++;
      $display("FAIL async_reset got EN/RE/WE/OE/HLT=%b ADDR=%h DATA_O=%h DATAI=%h expected all 0",
               {EN, RE, WE, DATA_OE, HLT}, ADDR, DATA_O, DATAI);
    end
    RD = 1'b0;
    exp_q.delete();
    wr_delay = 0;
    @(negedge CLK);
    @(negedge CLK);
    RES_N = 1'b1;
    rd_delay = 0; rd_word = 32'h0BAD_C0DE;
    exp_q.push_back('{1'b0, 32'h8000_0700, 32'h0});
    run_access(1'b1, 1'b0, 32'h8000_0700, 32'h0, 4'hF);
    checks++;
    if (run_to || hlt_cyc != 2 || done_datai !== 32'h0BAD_C0DE) begin
      failures++;
      $display("FAIL read_after_reset got to=%0d hlt=%0d DATAI=%h expected 0/2/0badc0de", run_to, hlt_cyc, done_datai);
    end
  endtask

`ifdef DBUS_TIMEOUT_EN
  task automatic test_timeout();
    rd_delay = 1000;
    run_access(1'b1, 1'b0, 32'h8000_0800, 32'h0, 4'hF);
    checks++;
    if (run_to || hlt_cyc != 9 || done_datai !== 32'hFFFF_FFFF || ERR !== 1'b1) begin
      failures++;
      $display("FAIL timeout got to=%0d hlt=%0d DATAI=%h ERR=%b expected 0/9/ffffffff/1", run_to, hlt_cyc, done_datai, ERR);
    end
    @(negedge CLK);
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    #1;
    checks++;
    if (ERR !== 1'b0) begin
      failures++;
      $display("FAIL err_clr got ERR=%b expected 0", ERR);
    end
    rd_delay = 0;
  endtask
`else
  task automatic test_no_err();
    checks++;
    if (ERR !== 1'b0) begin
      failures++;
      $display("FAIL err_tied got ERR=%b expected 0", ERR);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_wait();
    test_full_write();
    test_rmw();
    test_miss_and_empty();
    test_back_to_back();
    test_reset_mid_write();
`ifdef DBUS_TIMEOUT_EN
    test_timeout();
`else
    test_no_err();
`endif
    repeat (2) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
